// File: rtl/div_share_pkg.sv
// Shared types, width defaults and helpers for the divider-sharing controller.
package div_share_pkg;

    localparam int DVD_W_DEF = 10;
    localparam int DVS_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, cyclically.
// Returns the winner both one-hot and as an index, plus a found flag.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             found
);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % N_REQ]) begin
                grant[(int'(ptr) + k) % N_REQ] = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % N_REQ);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential restoring divider among N_REQ requesters in round-robin order.
// Optional macro DIV_OVF_CHECK_EN rejects operands whose quotient cannot fit, without starting the divider.
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  DVD_W   = DVD_W_DEF,
    parameter int  DVS_W   = DVS_W_DEF,
    parameter int  TIMEOUT = 64,
    localparam int ID_W    = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DVD_W-1:0] req_dvd,
    input  logic [N_REQ*DVS_W-1:0] req_dvs,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DVS_W-1:0]       rsp_q,
    output logic [DVS_W-1:0]       rsp_r,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   div_start,
    output logic [DVD_W-1:0]       div_dvd,
    output logic [DVS_W-1:0]       div_dvs,
    input  logic [DVS_W-1:0]       div_q,
    input  logic [DVS_W-1:0]       div_r,
    input  logic                   div_ready,
    output state_t                 dbg_state
);

    // Handshake: req is a level held by the client until it sees rsp_valid with its id;
    // rsp_valid is a one-cycle strobe without back-pressure and rsp_id/q/r/err hold until
    // the next response. div_start is a one-cycle pulse; div_ready is trusted only from
    // the second WAIT cycle so an idle-high ready left over from before the start is ignored.

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [CNT_W-1:0]   wait_cnt;

    logic [N_REQ-1:0]   grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [DVD_W-1:0]   win_dvd;
    logic [DVS_W-1:0]   win_dvs;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_LAST) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .found (grant_any)
    );

    // One-hot operand mux driven by the arbiter grant.
    always_comb begin
        win_dvd = '0;
        win_dvs = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                win_dvd = win_dvd | req_dvd[i*DVD_W +: DVD_W];
                win_dvs = win_dvs | req_dvs[i*DVS_W +: DVS_W];
            end
        end
    end

`ifdef DIV_OVF_CHECK_EN
    logic win_ovf;
    // Quotient would need more than DVS_W bits; also true for a zero divisor.
    assign win_ovf = (win_dvd[DVD_W-1:DVS_W] >= win_dvs);
`endif

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cur_id    <= '0;
            wait_cnt  <= '0;
            div_start <= 1'b0;
            div_dvd   <= '0;
            div_dvs   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        div_dvd  <= win_dvd;
                        div_dvs  <= win_dvs;
                        cur_id   <= grant_idx;
                        wait_cnt <= '0;
`ifdef DIV_OVF_CHECK_EN
                        if (win_ovf) begin
                            rr_ptr    <= next_id(grant_idx);
                            rsp_valid <= 1'b1;
                            rsp_id    <= grant_idx;
                            rsp_q     <= '0;
                            rsp_r     <= '0;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
`else
                        div_start <= 1'b1;
                        state     <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    rr_ptr   <= next_id(cur_id);
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != '0 && div_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        rsp_err   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_q     <= '0;
                        rsp_r     <= '0;
                        rsp_err   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: behavioural divider, arbitration model with expected queue,
// directed scenarios with literal results, then randomized request mixes.
module tb_div_share_ctrl;
    import div_share_pkg::*;

    localparam int N_REQ   = 4;
    localparam int DVD_W   = 10;
    localparam int DVS_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = 2;
    localparam int DIV_CYC = 6;
    localparam int EW      = ID_W + 2*DVS_W + 2;
    localparam int LW      = ID_W + 2*DVS_W + 1;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DVD_W-1:0] req_dvd;
    logic [N_REQ*DVS_W-1:0] req_dvs;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DVS_W-1:0]       rsp_q;
    logic [DVS_W-1:0]       rsp_r;
    logic                   rsp_err;
    logic                   busy;
    logic                   div_start;
    logic [DVD_W-1:0]       div_dvd;
    logic [DVS_W-1:0]       div_dvs;
    logic [DVS_W-1:0]       div_q;
    logic [DVS_W-1:0]       div_r;
    logic                   div_ready;
    state_t                 dbg_state;

    logic                   hang;
    int                     n_checks;
    int                     n_fail;
    int                     start_cnt;
    int                     n_starts;
    logic [EW-1:0]          exp_q[$];
    logic [LW-1:0]          log_q[$];
    logic [ID_W-1:0]        m_ptr;
    logic                   m_busy;

    div_share_ctrl #(
        .N_REQ   (N_REQ),
        .DVD_W   (DVD_W),
        .DVS_W   (DVS_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_dvd   (req_dvd),
        .req_dvs   (req_dvs),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .div_start (div_start),
        .div_dvd   (div_dvd),
        .div_dvs   (div_dvs),
        .div_q     (div_q),
        .div_r     (div_r),
        .div_ready (div_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic divider result; a zero divisor yields all-ones quotient.
    function automatic logic [2*DVS_W-1:0] div_ref(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b);
        int q;
        int r;
        if (b == '0) begin
            q = (1 << DVS_W) - 1;
            r = int'(a) % (1 << DVS_W);
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        return {DVS_W'(q), DVS_W'(r)};
    endfunction

    // Expected entry {id, q, r, err, started} for a grant to requester id.
    function automatic logic [EW-1:0] predict(input int id, input logic [DVD_W-1:0] a,
                                               input logic [DVS_W-1:0] b, input logic hung);
        bit ovf;
        ovf = 1'b0;
`ifdef DIV_OVF_CHECK_EN
        ovf = (int'(a) >= int'(b) * (1 << DVS_W));
`endif
        if (ovf)
            return {ID_W'(id), {2*DVS_W{1'b0}}, 1'b1, 1'b0};
        else if (hung)
            return {ID_W'(id), {2*DVS_W{1'b0}}, 1'b1, 1'b1};
        else
            return {ID_W'(id), div_ref(a, b), 1'b0, 1'b1};
    endfunction

    // ---------------- divider model (ready idles high, drops one cycle after start) ----------------
    logic [3:0]       dcnt;
    logic [DVD_W-1:0] d_dvd;
    logic [DVS_W-1:0] d_dvs;

    always @(posedge clk) begin
        if (rst) begin
            div_ready <= 1'b1;
            dcnt      <= 4'd0;
            div_q     <= '0;
            div_r     <= '0;
        end else if (div_start) begin
            dcnt  <= 4'(DIV_CYC);
            d_dvd <= div_dvd;
            d_dvs <= div_dvs;
        end else if (dcnt != 4'd0) begin
            dcnt <= dcnt - 4'd1;
            if (dcnt == 4'd1 && !hang) begin
                div_ready      <= 1'b1;
                {div_q, div_r} <= div_ref(d_dvd, d_dvs);
            end else begin
                div_ready <= 1'b0;
            end
        end
    end

    // ---------------- arbitration model: one op at a time, round-robin from m_ptr ----------------
    initial begin : model
        int id;
        m_ptr  = '0;
        m_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0;
                m_ptr  = '0;
                exp_q.delete();
            end else if (m_busy) begin
                if (rsp_valid) m_busy = 1'b0;
            end else if (req != '0) begin
                id = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (id < 0 && req[(int'(m_ptr) + k) % N_REQ]) id = (int'(m_ptr) + k) % N_REQ;
                m_ptr = ID_W'((id + 1) % N_REQ);
                exp_q.push_back(predict(id, req_dvd[id*DVD_W +: DVD_W], req_dvs[id*DVS_W +: DVS_W], hang));
                m_busy = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin : compare
        logic [EW-1:0] e;
        start_cnt = 0;
        n_starts  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                start_cnt = 0;
            end else begin
                if (div_start) begin
                    start_cnt++;
                    n_starts++;
                end
                check("busy", 32'(busy), 32'(m_busy));
                if (rsp_valid) begin
                    log_q.push_back({rsp_id, rsp_q, rsp_r, rsp_err});
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id",     32'(rsp_id),  32'(e[2+2*DVS_W +: ID_W]));
                        check("rsp_q",      32'(rsp_q),   32'(e[2+DVS_W +: DVS_W]));
                        check("rsp_r",      32'(rsp_r),   32'(e[2 +: DVS_W]));
                        check("rsp_err",    32'(rsp_err), 32'(e[1]));
                        check("rsp_starts", 32'(start_cnt), 32'(e[0]));
                    end
                    start_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_zero(input string name);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({name, "_rsp_q"},     32'(rsp_q),     32'd0);
        check({name, "_rsp_r"},     32'(rsp_r),     32'd0);
        check({name, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
        check({name, "_div_start"}, 32'(div_start), 32'd0);
        check({name, "_div_dvd"},   32'(div_dvd),   32'd0);
        check({name, "_div_dvs"},   32'(div_dvs),   32'd0);
        check({name, "_state"},     32'(dbg_state), 32'(IDLE));
    endtask

    task automatic do_reset();
        req  = '0;
        hang = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        log_q.delete();
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_dvd[i*DVD_W +: DVD_W] = DVD_W'(a);
        req_dvs[i*DVS_W +: DVS_W] = DVS_W'(b);
        req[i] = 1'b1;
    endtask

    // Requesters drop req after their response (n_hold=0), or all hold until n_hold responses.
    task automatic serve(input string name, input int n_hold, input int budget, output int lat);
        int seen;
        bit done;
        seen = 0;
        done = 1'b0;
        lat  = 0;
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen++;
                if (lat == 0) lat = c;
                if (n_hold == 0) req[rsp_id] = 1'b0;
                else if (seen >= n_hold) req = '0;
            end else if (req == '0 && !busy) begin
                done = 1'b1;
            end
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic expect_log(input string name, input int k, input int id, input int q,
                              input int r, input int e);
        logic [LW-1:0] want;
        want = {ID_W'(id), DVS_W'(q), DVS_W'(r), 1'(e)};
        if (k < log_q.size()) check(name, 32'(log_q[k]), 32'(want));
        else check({name, "_missing"}, 32'(log_q.size()), 32'(k + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int lat;
        int s0;
        int mask;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_dvd  = '0;
        req_dvs  = '0;
        hang     = 1'b0;
        @(negedge clk);

        // single request, latency 3 + divider cycles
        do_reset();
        set_op(0, 26, 5);
        serve("s1", 0, 200, lat);
        check("s1_latency", 32'(lat), 32'(3 + DIV_CYC));
        expect_log("s1_r0", 0, 0, 5, 1, 0);

        // three simultaneous requests, then requester 0, then pointer kept across idle
        do_reset();
        set_op(1, 22, 3);
        set_op(2, 54, 7);
        set_op(3, 150, 15);
        serve("s2a", 0, 300, lat);
        set_op(0, 214, 14);
        serve("s2b", 0, 200, lat);
        repeat (10) @(negedge clk);
        set_op(0, 31, 31);
        set_op(3, 100, 9);
        serve("s2c", 0, 300, lat);
        expect_log("s2_r0", 0, 1, 7, 1, 0);
        expect_log("s2_r1", 1, 2, 7, 5, 0);
        expect_log("s2_r2", 2, 3, 10, 0, 0);
        expect_log("s2_r3", 3, 0, 15, 4, 0);
        expect_log("s2_r4", 4, 3, 11, 1, 0);
        expect_log("s2_r5", 5, 0, 1, 0, 0);

        // fairness with all four held
        do_reset();
        set_op(0, 100, 7);
        set_op(1, 63, 8);
        set_op(2, 200, 13);
        set_op(3, 9, 2);
        serve("s3", 5, 500, lat);
        expect_log("s3_r0", 0, 0, 14, 2, 0);
        expect_log("s3_r1", 1, 1, 7, 7, 0);
        expect_log("s3_r2", 2, 2, 15, 5, 0);
        expect_log("s3_r3", 3, 3, 4, 1, 0);
        expect_log("s3_r4", 4, 0, 14, 2, 0);

        // divider never becomes ready
        do_reset();
        hang = 1'b1;
        set_op(2, 26, 5);
        serve("s4", 0, 300, lat);
        check("s4_latency", 32'(lat), 32'(TIMEOUT + 2));
        expect_log("s4_r0", 0, 2, 0, 0, 1);
        check("s4_idle", 32'(dbg_state), 32'(IDLE));

        // overflow vectors
        do_reset();
        s0 = n_starts;
        set_op(0, 600, 5);
        serve("s5a", 0, 200, lat);
        set_op(1, 26, 0);
        serve("s5b", 0, 200, lat);
`ifdef DIV_OVF_CHECK_EN
        check("s5_starts", 32'(n_starts - s0), 32'd0);
        expect_log("s5_r0", 0, 0, 0, 0, 1);
        expect_log("s5_r1", 1, 1, 0, 0, 1);
`else
        check("s5_starts", 32'(n_starts - s0), 32'd2);
        expect_log("s5_r0", 0, 0, 24, 0, 0);
        expect_log("s5_r1", 1, 1, 31, 26, 0);
`endif

        // reset while waiting on the divider
        do_reset();
        set_op(0, 26, 5);
        for (int c = 0; c < 20 && dbg_state != WAIT; c++) @(negedge clk);
        check("s6_in_wait", 32'(dbg_state), 32'(WAIT));
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk_zero("s6_abort");
        check("s6_no_rsp", 32'(log_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        set_op(0, 26, 5);
        serve("s6", 0, 200, lat);
        expect_log("s6_r0", 0, 0, 5, 1, 0);

        // randomized request mixes
        do_reset();
        for (int n = 0; n < 40; n++) begin
            mask = int'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++)
                if (mask[i]) set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
            serve("rnd", 0, 1000, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
